// File: rtl/if_fetch_buffer.sv
// In-order instruction fetch buffer between the imem port and the IF/ID register.
// Optional same-cycle response bypass to ID: define IF_BUF_BYPASS_EN.
module if_fetch_buffer #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_flush_i,
  input  logic        if_id_stall_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_req_pc_i,
  output logic        fetch_req_ready_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        if_d_valid,
  output logic [31:0] if_d_pc,
  output logic [31:0] if_d_pc_plus_4,
  output logic [31:0] if_d_insn,
  output logic        if_d_access_fault,
  output logic        if_buf_empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = CW + 1;
  localparam logic [PW-1:0] PF_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [CW-1:0] occ_q, inflight_q;
  logic [DW-1:0] discard_q;
  logic [AW-1:0] head_q, tail_q;
  logic [PW-1:0] pf_wr_q, pf_rd_q;

  logic [31:0] pf_mem [MAX_OUTSTANDING];
  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_insn [DEPTH];
  logic        q_err  [DEPTH];

  logic [SW-1:0] credit_sum;
  logic [SW-1:0] disc_sum;
  logic [SW-1:0] disc_flush;
  logic          req_acc;
  logic          rsp_take;
  logic          rsp_drop;
  logic          head_valid;
  logic          deq;
  logic          enq;

  // Handshake: a request transfers on a cycle where fetch_req_i && fetch_req_ready_o;
  // ready already reserves a queue slot, so imem responses are never backpressured.
  assign credit_sum        = SW'(occ_q) + SW'(inflight_q);
  assign fetch_req_ready_o = (credit_sum < SW'(DEPTH)) &&
                             (inflight_q < CW'(MAX_OUTSTANDING)) && !if_flush_i;
  assign req_acc           = fetch_req_i && fetch_req_ready_o;

  assign rsp_drop   = imem_rvalid_i && (discard_q != '0);
  assign rsp_take   = imem_rvalid_i && (discard_q == '0) && (inflight_q != '0) && !if_flush_i;
  assign head_valid = (occ_q != '0);
  assign deq        = head_valid && !if_id_stall_i && !if_flush_i;

`ifdef IF_BUF_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = rsp_take && !head_valid && !if_id_stall_i;
  assign enq        = rsp_take && !bypass_hit;
`else
  assign enq        = rsp_take;
`endif

  // Responses still owed for requests issued before a redirect become discards.
  assign disc_sum   = SW'(discard_q) + SW'(inflight_q);
  assign disc_flush = (imem_rvalid_i && (disc_sum != '0)) ? disc_sum - SW'(1) : disc_sum;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occ_q      <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pf_wr_q    <= '0;
      pf_rd_q    <= '0;
    end else if (if_flush_i) begin
      occ_q      <= '0;
      inflight_q <= '0;
      discard_q  <= DW'(disc_flush);
      head_q     <= '0;
      tail_q     <= '0;
      pf_wr_q    <= '0;
      pf_rd_q    <= '0;
    end else begin
      if (req_acc)  pf_wr_q <= (pf_wr_q == PF_LAST) ? '0 : pf_wr_q + PW'(1);
      if (rsp_take) pf_rd_q <= (pf_rd_q == PF_LAST) ? '0 : pf_rd_q + PW'(1);
      if (enq)      tail_q  <= tail_q + AW'(1);
      if (deq)      head_q  <= head_q + AW'(1);
      if (rsp_drop) discard_q <= discard_q - DW'(1);
      case ({req_acc, rsp_take})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
      case ({enq, deq})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_acc) pf_mem[pf_wr_q] <= fetch_req_pc_i;
    if (enq) begin
      q_pc[tail_q]   <= pf_mem[pf_rd_q];
      q_insn[tail_q] <= imem_rdata_i;
      q_err[tail_q]  <= imem_err_i;
    end
  end

  always_comb begin
    if_d_valid        = 1'b0;
    if_d_pc           = 32'h0;
    if_d_insn         = NOP;
    if_d_access_fault = 1'b0;
    if (head_valid) begin
      if_d_valid        = 1'b1;
      if_d_pc           = q_pc[head_q];
      if_d_insn         = q_insn[head_q];
      if_d_access_fault = q_err[head_q];
    end
`ifdef IF_BUF_BYPASS_EN
    else if (bypass_hit) begin
      if_d_valid        = 1'b1;
      if_d_pc           = pf_mem[pf_rd_q];
      if_d_insn         = imem_rdata_i;
      if_d_access_fault = imem_err_i;
    end
`endif
  end

  assign if_d_pc_plus_4 = if_d_pc + 32'd4;
  assign if_buf_empty_o = !if_d_valid;

`ifdef FORMAL
  always @(posedge clk_i) begin
    if (rst_i) assert (!(imem_rvalid_i && (inflight_q == '0) && (discard_q == '0)));
  end
`endif

endmodule
